// File: rtl/mmu_ram_pkg.sv
// Shared types and default geometry for the IMMU/DMMU TLB RAM arrays.
package mmu_ram_pkg;

    // Flush sequencer states: IDLE serves user accesses, FLUSH owns the array.
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    // Default geometry of the ITLB/DTLB match and translate arrays.
    localparam int TLB_DW    = 14;
    localparam int TLB_AW    = 6;
    localparam int TLB_DEPTH = 64;

    // Index width for an array of the given depth; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mmu_ram_flush_ctrl.sv
// Flush sequencer: after reset or on request, walks every entry once so the
// top level can write the invalidate value into it.
module mmu_ram_flush_ctrl
    import mmu_ram_pkg::*;
#(
    parameter int  DEPTH = TLB_DEPTH,
    localparam int CW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_req,
    output logic          flush_busy,
    output logic          flush_we,
    output logic [CW-1:0] flush_addr
);

    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    flush_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next state: requests are only honoured in IDLE; the walk ends after the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    // State register: reset lands in FLUSH at entry 0 so every reset scrubs the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs: one entry is written per FLUSH cycle, addressed by the counter.
    always_comb begin
        flush_busy = (state_q == FLUSH);
        flush_we   = (state_q == FLUSH);
        flush_addr = cnt_q;
    end

endmodule

// File: rtl/mmu_tlb_ram.sv
// Parametrised single-port TLB RAM with built-in invalidate-all sequencer,
// optional output register, read-valid strobe and out-of-range handling.
module mmu_tlb_ram
    import mmu_ram_pkg::*;
#(
    parameter int             DW        = TLB_DW,
    parameter int             AW        = TLB_AW,
    parameter int             DEPTH     = TLB_DEPTH,
    parameter int             OUT_REG   = 0,
    parameter logic [DW-1:0]  FLUSH_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] di,
    input  logic          oe,
    output logic [DW-1:0] do_q,
    output logic          rd_valid,
    input  logic          flush_req,
    output logic          flush_busy
);

    localparam int            IW        = idx_width(DEPTH);
    localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic          flush_we;
    logic [IW-1:0] flush_addr;
    logic          in_range;
    logic          user_rd;
    logic          user_wr;
    logic          mem_we;
    logic [IW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic          rd1_q, rd1_d;
    logic [DW-1:0] data1_q, data1_d;
    logic          rd_out;
    logic [DW-1:0] data_out;

    mmu_ram_flush_ctrl #(
        .DEPTH (DEPTH)
    ) u_flush_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_we   (flush_we),
        .flush_addr (flush_addr)
    );

    // Port arbitration: the sequencer owns the array while busy; user writes outside the array are dropped.
    always_comb begin
        in_range  = ({1'b0, addr} < DEPTH_LIM);
        user_rd   = ce & ~we & ~flush_busy;
        user_wr   = ce & we & ~flush_busy & in_range;
        mem_we    = flush_we | user_wr;
        mem_addr  = flush_we ? flush_addr : addr[IW-1:0];
        mem_wdata = flush_we ? FLUSH_VAL : di;
    end

    // Storage array: contents are deliberately not reset, the sequencer scrubs them instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // First read stage: capture on an accepted read (zero when out of range), otherwise hold.
    always_comb begin
        rd1_d   = user_rd;
        data1_d = data1_q;
        if (user_rd) begin
            data1_d = in_range ? mem[addr[IW-1:0]] : '0;
        end
    end

    // First read stage register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_q   <= 1'b0;
            data1_q <= '0;
        end else begin
            rd1_q   <= rd1_d;
            data1_q <= data1_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic          rd2_q, rd2_d;
        logic [DW-1:0] data2_q, data2_d;

        // Second read stage: forwards only fresh read data so the output holds between reads.
        always_comb begin
            rd2_d   = rd1_q;
            data2_d = rd1_q ? data1_q : data2_q;
        end

        // Second read stage register, cleared by reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd2_q   <= 1'b0;
                data2_q <= '0;
            end else begin
                rd2_q   <= rd2_d;
                data2_q <= data2_d;
            end
        end

        assign rd_out   = rd2_q;
        assign data_out = data2_q;
    end else begin : g_no_out_reg
        assign rd_out   = rd1_q;
        assign data_out = data1_q;
    end

    // Output gating: oe only masks the data bus, never the strobe or stored state.
    always_comb begin
        do_q     = oe ? data_out : '0;
        rd_valid = rd_out;
    end

endmodule

// File: tb/tb_mmu_tlb_ram.sv
// Self-checking bench: three TLB RAM variants (latency 1, latency 2, 48 entries)
// driven in lockstep and checked every cycle against a reference model scoreboard.
module tb_mmu_tlb_ram;

    typedef struct {
        int          due;
        logic [13:0] data;
    } expT;

    int dep[3] = '{64, 64, 48};
    int lat[3] = '{1, 2, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic        oe = 1'b1;
    logic        flushReq = 1'b0;
    logic [5:0]  addr = '0;
    logic [13:0] di = '0;

    logic [13:0] dq0, dq1, dq2;
    logic        rv0, rv1, rv2;
    logic        fb0, fb1, fb2;
    logic [13:0] dq[3];
    logic        rv[3];
    logic        fb[3];

    expT         sbq[3][$];
    logic [13:0] model[3][64];
    logic [13:0] last[3];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    assign dq[0] = dq0;
    assign dq[1] = dq1;
    assign dq[2] = dq2;
    assign rv[0] = rv0;
    assign rv[1] = rv1;
    assign rv[2] = rv2;
    assign fb[0] = fb0;
    assign fb[1] = fb1;
    assign fb[2] = fb2;

    mmu_tlb_ram #(.DW(14), .AW(6), .DEPTH(64), .OUT_REG(0), .FLUSH_VAL(14'h0)) u0 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .di(di), .oe(oe),
        .do_q(dq0), .rd_valid(rv0), .flush_req(flushReq), .flush_busy(fb0));

    mmu_tlb_ram #(.DW(14), .AW(6), .DEPTH(64), .OUT_REG(1), .FLUSH_VAL(14'h0)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .di(di), .oe(oe),
        .do_q(dq1), .rd_valid(rv1), .flush_req(flushReq), .flush_busy(fb1));

    mmu_tlb_ram #(.DW(14), .AW(6), .DEPTH(48), .OUT_REG(0), .FLUSH_VAL(14'h0)) u2 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .di(di), .oe(oe),
        .do_q(dq2), .rd_valid(rv2), .flush_req(flushReq), .flush_busy(fb2));

    always #5 clk = ~clk;

    // Cycle counter used to timestamp when each expected read result is due.
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts it and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One stimulus cycle: drive after the edge and update the model/scoreboard for accepted accesses.
    task automatic applyStimulus(input logic c, input logic w, input logic [5:0] a,
                                 input logic [13:0] d, input logic f, input bit busy);
        expT e;
        @(posedge clk);
        #1;
        ce       = c;
        we       = w;
        addr     = a;
        di       = d;
        flushReq = f;
        if (c && !busy) begin
            for (int k = 0; k < 3; k++) begin
                if (w) begin
                    if (int'(a) < dep[k]) model[k][a] = d;
                end else begin
                    e.due  = cyc + lat[k];
                    e.data = (int'(a) < dep[k]) ? model[k][a] : 14'h0;
                    sbq[k].push_back(e);
                end
            end
        end
    endtask

    // Counts flush_busy cycles per instance (optionally issuing reads meanwhile), then clears the model.
    task automatic measureFlush(input string tag, input logic withCe);
        int cnt[3];
        cnt = '{0, 0, 0};
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (fb[k]) cnt[k]++;
            applyStimulus(withCe && (i < 40), 1'b0, 6'd63, 14'h0, 1'b0, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s_len%0d", tag, k), 32'(cnt[k]), 32'(dep[k]));
            for (int a = 0; a < 64; a++) model[k][a] = 14'h0;
        end
    endtask

    // Per-cycle monitor: due entries must appear with rd_valid, otherwise do_q holds and rd_valid is low.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                last[k] = 14'h0;
                checkOutput($sformatf("rst_rv%0d", k), 32'(rv[k]), 32'd0);
                checkOutput($sformatf("rst_do%0d", k), 32'(dq[k]), 32'd0);
            end else if (sbq[k].size() != 0 && sbq[k][0].due == cyc) begin
                last[k] = sbq[k][0].data;
                void'(sbq[k].pop_front());
                checkOutput($sformatf("rd_valid%0d", k), 32'(rv[k]), 32'd1);
                checkOutput($sformatf("rd_data%0d", k), 32'(dq[k]), oe ? 32'(last[k]) : 32'd0);
            end else begin
                checkOutput($sformatf("no_valid%0d", k), 32'(rv[k]), 32'd0);
                checkOutput($sformatf("hold%0d", k), 32'(dq[k]), oe ? 32'(last[k]) : 32'd0);
            end
        end
    end

    // Watchdog so the run always ends even if the DUT wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        for (int k = 0; k < 3; k++) begin
            last[k] = 14'h0;
            for (int a = 0; a < 64; a++) model[k][a] = 14'h0;
        end
        $display("[TB] start");

        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("init_busy%0d", k), 32'(fb[k]), 32'd1);
            checkOutput($sformatf("init_do%0d", k), 32'(dq[k]), 32'd0);
            checkOutput($sformatf("init_rv%0d", k), 32'(rv[k]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        measureFlush("rst_flush", 1'b1);

        // Every entry reads back as the flush value.
        for (int a = 0; a < 64; a++) applyStimulus(1'b1, 1'b0, 6'(a), 14'h0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b0);

        // Write then read back.
        applyStimulus(1'b1, 1'b1, 6'd5, 14'h2A5B, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd5, 14'h0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b0);

        // Requested flush; the read issued alongside the request still executes.
        applyStimulus(1'b1, 1'b1, 6'd63, 14'h1234, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd63, 14'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd5, 14'h0, 1'b1, 1'b0);
        measureFlush("req_flush", 1'b1);
        applyStimulus(1'b1, 1'b0, 6'd63, 14'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd5, 14'h0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b0);

        // Out-of-range on the 48-entry variant: write dropped, read zero, aliased entry intact.
        applyStimulus(1'b1, 1'b1, 6'd2, 14'h0ABC, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 6'd50, 14'h3FFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd50, 14'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd2, 14'h0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b0);

        // Streamed reads, then the same stream with the output masked.
        for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b1, 6'(a), 14'(a + 1), 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b0, 6'(a), 14'h0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b0);
        oe = 1'b0;
        for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b0, 6'(a), 14'h0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b0);
        oe = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b0);

        // Reset in the middle of a flush restarts the full walk.
        applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b1, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("midrst_do%0d", k), 32'(dq[k]), 32'd0);
            checkOutput($sformatf("midrst_rv%0d", k), 32'(rv[k]), 32'd0);
            checkOutput($sformatf("midrst_busy%0d", k), 32'(fb[k]), 32'd1);
        end
        repeat (2) applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        measureFlush("post_rst_flush", 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 6'd0, 14'h0, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("sb_empty%0d", k), 32'(sbq[k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
